// File: rtl/acc_readout_serializer.sv
// acc_readout_serializer
// Drains NUM_CH show-ahead accumulator buffers round-robin, one word per
// channel per turn, into a byte stream with a valid/rd_en handshake.
// Each record is NUM_CH*WORDS_PER_CH*WORD_BYTES bytes long.
// Optional feature macro: ACC_SERIALIZER_EOD_MARKER_EN
//   defined   -> four in-band marker bytes 80 01 01 80 follow each record,
//                flagged with eod_flag_o; record_done_o follows the last marker.
//   undefined -> no marker state, eod_flag_o tied low; record_done_o follows
//                the last data byte.
module acc_readout_serializer #(
  parameter int NUM_CH       = 4,
  parameter int WORD_BYTES   = 2,
  parameter int WORDS_PER_CH = 128,
  parameter int READY_ALL    = 0,
  parameter int MSB_FIRST    = 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NUM_CH-1:0]              ch_ready_i,
  input  logic [NUM_CH*WORD_BYTES*8-1:0] ch_data_i,
  output logic [NUM_CH-1:0]              ch_rd_o,
  input  logic                           abort_i,
  input  logic                           rd_en_i,
  output logic [7:0]                     data_out_o,
  output logic                           data_valid_o,
  output logic                           eod_flag_o,
  output logic                           busy_o,
  output logic                           record_done_o
);

  localparam int WORD_W = WORD_BYTES * 8;
  localparam int TOTAL  = NUM_CH * WORDS_PER_CH * WORD_BYTES;
  localparam int CNT_W  = $clog2(TOTAL + 1);
  localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  // Mux tables are padded to a power of two so every index value is in range.
  localparam int SLOTS  = 2 ** SEL_W;
  localparam int LANES  = 2 ** BIDX_W;

  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(NUM_CH - 1);
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(WORD_BYTES - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TOTAL - 1);

`ifdef ACC_SERIALIZER_EOD_MARKER_EN
  typedef enum logic [1:0] {S_IDLE, S_XFER, S_EOD} state_e;
`else
  typedef enum logic {S_IDLE, S_XFER} state_e;
`endif

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [BIDX_W-1:0]  bidx_q, bidx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
`ifdef ACC_SERIALIZER_EOD_MARKER_EN
  logic [1:0]         mark_q, mark_d;
  logic [7:0]         mark_byte;
`endif

  logic               start_cond;
  logic [WORD_W-1:0]  ch_words [SLOTS];
  logic [WORD_W-1:0]  sel_word;
  logic [7:0]         lane_bytes [LANES];
  logic [BIDX_W-1:0]  lane_idx;
  logic [7:0]         cur_byte;
  logic [NUM_CH-1:0]  sel_onehot;

  // Start qualifier: any channel ready, or every channel ready.
  generate
    if (READY_ALL != 0) begin : g_ready_all
      assign start_cond = &ch_ready_i;
    end else begin : g_ready_any
      assign start_cond = |ch_ready_i;
    end
  endgenerate

  // Unpack the flat channel bus into one word per channel slot.
  generate
    for (genvar gi = 0; gi < SLOTS; gi++) begin : g_word
      if (gi < NUM_CH) begin : g_real
        assign ch_words[gi] = ch_data_i[gi*WORD_W +: WORD_W];
      end else begin : g_pad
        assign ch_words[gi] = '0;
      end
    end
  endgenerate

  assign sel_word = ch_words[sel_q];

  // Split the selected word into byte lanes (lane 0 = least significant).
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      if (gi < WORD_BYTES) begin : g_real
        assign lane_bytes[gi] = sel_word[gi*8 +: 8];
      end else begin : g_pad
        assign lane_bytes[gi] = 8'h00;
      end
    end
  endgenerate

  // Byte order within a word: the registered byte index counts transfer
  // order, so MSB-first walks the lanes downward.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign lane_idx = BIDX_LAST - bidx_q;
    end else begin : g_lsb_first
      assign lane_idx = bidx_q;
    end
  endgenerate

  assign cur_byte = lane_bytes[lane_idx];

  // One-hot decode of the selected channel, used for the pop pulse.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_onehot
      assign sel_onehot[gi] = (sel_q == SEL_W'(gi));
    end
  endgenerate

`ifdef ACC_SERIALIZER_EOD_MARKER_EN
  // End-of-data marker sequence 80 01 01 80.
  assign mark_byte = (mark_q == 2'd0 || mark_q == 2'd3) ? 8'h80 : 8'h01;
`endif

  // Next-state and handshake outputs; abort overrides everything last.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    bidx_d       = bidx_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
`ifdef ACC_SERIALIZER_EOD_MARKER_EN
    mark_d       = mark_q;
`endif
    ch_rd_o      = '0;
    data_out_o   = 8'h00;
    data_valid_o = 1'b0;
    eod_flag_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_cond) begin
          state_d = S_XFER;
          sel_d   = '0;
          bidx_d  = '0;
          cnt_d   = '0;
        end
      end

      S_XFER: begin
        data_valid_o = 1'b1;
        data_out_o   = cur_byte;
        if (rd_en_i) begin
          bidx_d = bidx_q + BIDX_W'(1);
          cnt_d  = cnt_q + CNT_W'(1);
          // Last byte of the word: pop it and move to the next channel in
          // the same cycle so the next word is already presented.
          if (bidx_q == BIDX_LAST) begin
            ch_rd_o = sel_onehot;
            bidx_d  = '0;
            sel_d   = (sel_q == SEL_LAST) ? '0 : sel_q + SEL_W'(1);
          end
          if (cnt_q == CNT_LAST) begin
            sel_d  = '0;
            bidx_d = '0;
            cnt_d  = '0;
`ifdef ACC_SERIALIZER_EOD_MARKER_EN
            state_d = S_EOD;
            mark_d  = '0;
`else
            state_d = S_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end

`ifdef ACC_SERIALIZER_EOD_MARKER_EN
      S_EOD: begin
        data_valid_o = 1'b1;
        eod_flag_o   = 1'b1;
        data_out_o   = mark_byte;
        if (rd_en_i) begin
          mark_d = mark_q + 2'd1;
          if (mark_q == 2'd3) begin
            state_d = S_IDLE;
            mark_d  = '0;
            done_d  = 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort: back to IDLE with everything cleared, no pop, no completion.
    if (abort_i) begin
      state_d = S_IDLE;
      sel_d   = '0;
      bidx_d  = '0;
      cnt_d   = '0;
      done_d  = 1'b0;
`ifdef ACC_SERIALIZER_EOD_MARKER_EN
      mark_d  = '0;
`endif
      ch_rd_o = '0;
    end
  end

  // State, indices and counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      bidx_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
`ifdef ACC_SERIALIZER_EOD_MARKER_EN
      mark_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      bidx_q  <= bidx_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
`ifdef ACC_SERIALIZER_EOD_MARKER_EN
      mark_q  <= mark_d;
`endif
    end
  end

  assign busy_o        = (state_q != S_IDLE);
  assign record_done_o = done_q;

endmodule
